// File: rtl/timer_pkg.sv
// Shared constants and types for the timer counter chain.
package timer_pkg;
  localparam int BCD_W    = 4;
  localparam int ONES_MAX = 9;
  localparam int TENS_MAX = 5;

  typedef logic [BCD_W-1:0] bcd_t;
endpackage

// File: rtl/bcd_digit.sv
// One counter digit: counts 0..MAX on enable, carry flags the wrapping cycle.
module bcd_digit #(
  parameter int WIDTH = 4,
  parameter int MAX   = 9
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_q,
  output logic             o_carry
);
  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX);

  logic [WIDTH-1:0] r_q;

  // i_rst_n is active high; the name is inherited from the timer codebase.
  always_ff @(posedge i_clk or posedge i_rst_n) begin
    if (i_rst_n)   r_q <= '0;
    else if (i_clr) r_q <= '0;
    else if (i_en)  r_q <= (r_q >= MAX_Q) ? '0 : r_q + 1'b1;
  end

  assign o_q     = r_q;
  assign o_carry = i_en & (r_q == MAX_Q);
endmodule

// File: rtl/mod60_bcd_counter.sv
// Modulo-60 packed-BCD counter; o_tc is the cascade enable for the next stage.
module mod60_bcd_counter
  import timer_pkg::*;
#(
  parameter int ONES_MAX = timer_pkg::ONES_MAX,
  parameter int TENS_MAX = timer_pkg::TENS_MAX
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  output logic       o_tc,
  output logic [6:0] o_cnt_num
);
  localparam bcd_t       ONES_LIM = BCD_W'(ONES_MAX);
  localparam logic [2:0] TENS_LIM = 3'(TENS_MAX);

  bcd_t       w_ones;
  logic [2:0] w_tens;
  logic       w_ones_carry;
  logic       w_tens_carry;
  logic       w_illegal;
  logic       w_clr;

  // An out-of-range digit (e.g. upset) must return the whole count to 00,
  // not just the offending digit, so both digits share one clear.
  assign w_illegal = (w_ones > ONES_LIM) | (w_tens > TENS_LIM);
  assign w_clr     = i_en & w_illegal;

  bcd_digit #(.WIDTH(BCD_W), .MAX(ONES_MAX)) u_ones (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (i_en),
    .i_clr   (w_clr),
    .o_q     (w_ones),
    .o_carry (w_ones_carry)
  );

  bcd_digit #(.WIDTH(3), .MAX(TENS_MAX)) u_tens (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (w_ones_carry),
    .i_clr   (w_clr),
    .o_q     (w_tens),
    .o_carry (w_tens_carry)
  );

  assign o_tc      = w_tens_carry & ~w_illegal;
  assign o_cnt_num = {w_tens, w_ones};
endmodule

// File: tb/tb_mod60_bcd_counter.sv
// Bench for mod60_bcd_counter: vector table plus hand-written corner sequences.
`timescale 1ns/1ps
module tb_mod60_bcd_counter;
  typedef struct {
    logic       rst;
    logic       en;
    logic [6:0] exp_cnt;
    logic       exp_tc;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       tc;
  logic [6:0] cnt;

  int   n_vec = 0;
  int   n_err = 0;
  int   m     = 0;
  int   pulses;
  logic obs_tc;
  vec_t tbl[$];
  vec_t sb[$];

  mod60_bcd_counter dut (
    .i_clk     (clk),
    .i_rst_n   (rst),
    .i_en      (en),
    .o_tc      (tc),
    .o_cnt_num (cnt)
  );

  always #10 clk = ~clk;

  function automatic logic [6:0] bcd(input int n);
    logic [6:0] r;
    r[6:4] = 3'(n / 10);
    r[3:0] = 4'(n % 10);
    return r;
  endfunction

  // Decimal reference model: tc is pre-edge, exp_cnt is post-edge.
  function automatic vec_t mk(input logic r, input logic e);
    vec_t v;
    v.rst = r;
    v.en  = e;
    if (r) begin
      v.exp_tc = 1'b0;
      m = 0;
    end else begin
      v.exp_tc = e && (m == 59);
      if (e) m = (m + 1) % 60;
    end
    v.exp_cnt = bcd(m);
    return v;
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_vec(input vec_t v);
    vec_t e;
    @(negedge clk);
    rst = v.rst;
    en  = v.en;
    sb.push_back(v);
    #5 obs_tc = tc;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("tc", {6'd0, obs_tc}, {6'd0, e.exp_tc});
    check("cnt", cnt, e.exp_cnt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset hold, release, one full wrap, gating at 37 and 59.
    for (int i = 0; i < 3; i++)  tbl.push_back(mk(1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0));
    for (int i = 0; i < 60; i++) tbl.push_back(mk(1'b0, 1'b1));
    for (int i = 0; i < 37; i++) tbl.push_back(mk(1'b0, 1'b1));
    for (int i = 0; i < 5; i++)  tbl.push_back(mk(1'b0, 1'b0));
    for (int i = 0; i < 22; i++) tbl.push_back(mk(1'b0, 1'b1));
    for (int i = 0; i < 3; i++)  tbl.push_back(mk(1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1));

    pulses = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      run_vec(tbl[i]);
      if (i >= 4 && i < 64 && obs_tc === 1'b1) pulses++;
    end
    check("tc_pulses_per_60", 7'(pulses), 7'd1);

    // Async reset between edges at 42.
    for (int i = 0; i < 42; i++) run_vec(mk(1'b0, 1'b1));
    check("cnt_at_42", cnt, 7'h42);
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    #1;
    check("async_rst_cnt", cnt, 7'h00);
    check("async_rst_tc", {6'd0, tc}, 7'd0);
    run_vec(mk(1'b1, 1'b0));
    run_vec(mk(1'b0, 1'b0));
    run_vec(mk(1'b0, 1'b1));
    run_vec(mk(1'b0, 1'b1));

    // Illegal ones digit with a nonzero tens digit.
    force dut.u_ones.r_q = 4'hC;
    force dut.u_tens.r_q = 3'h3;
    #1;
    release dut.u_ones.r_q;
    release dut.u_tens.r_q;
    #1;
    check("illegal_load_a", cnt, 7'h3C);
    run_vec('{rst: 1'b0, en: 1'b1, exp_cnt: 7'h00, exp_tc: 1'b0});

    // Illegal tens digit with ones at its max must not raise tc.
    force dut.u_ones.r_q = 4'h9;
    force dut.u_tens.r_q = 3'h6;
    #1;
    release dut.u_ones.r_q;
    release dut.u_tens.r_q;
    #1;
    check("illegal_load_b", cnt, 7'h69);
    run_vec('{rst: 1'b0, en: 1'b1, exp_cnt: 7'h00, exp_tc: 1'b0});
    m = 0;
    run_vec(mk(1'b0, 1'b1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
